// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-clk press/release/short/long/repeat event pulses.
// Latency: events are registered one clk after the ena edge that detects them; no backpressure (pure pulse outputs).
// Optional: define BTN_AUTOREPEAT_EN to enable repeat_pulse while a long press is held.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            // Pulses last one clk regardless of how sparse ena is.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (ena) begin
                case (state)
                    IDLE: begin
                        if (btn_in) begin
                            state       <= PRESSED;
                            cnt         <= '0;
                            press_pulse <= 1'b1;
                            held        <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!btn_in) begin
                            state         <= IDLE;
                            cnt           <= '0;
                            short_press   <= 1'b1;
                            release_pulse <= 1'b1;
                            held          <= 1'b0;
                        end else if (cnt == LONG_LAST) begin
                            state      <= LONG;
                            cnt        <= '0;
                            long_press <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LONG: begin
                        if (!btn_in) begin
                            state         <= IDLE;
                            cnt           <= '0;
                            release_pulse <= 1'b1;
                            held          <= 1'b0;
                        end
`ifdef BTN_AUTOREPEAT_EN
                        else if (cnt == REPEAT_LAST) begin
                            cnt          <= '0;
                            repeat_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifndef BTN_AUTOREPEAT_EN
    // Without auto-repeat the limit is never consulted.
    logic unused_repeat_last;
    assign unused_repeat_last = ^REPEAT_LAST;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=3.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic btn_in;
    logic press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;

    int checks   = 0;
    int failures = 0;

    // Per-ena-tick traces: bit t holds the output sampled after ena edge E<t>.
    logic [63:0] got [6];
    int          wide_err;
    string       names [6] = '{"press", "release", "short", "long", "repeat", "held"};

    button_event_decoder #(.LONG_CYCLES(8), .REPEAT_CYCLES(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    function automatic logic any_pulse();
        return press_pulse | release_pulse | short_press | long_press | repeat_pulse;
    endfunction

    // Holds btn_in high for high_ticks ena ticks, then low for one tick; ena fires every period clks.
    task automatic run_seq(input int high_ticks, input int period);
        for (int i = 0; i < 6; i++) got[i] = '0;
        wide_err = 0;
        for (int t = 0; t <= high_ticks; t++) begin
            for (int c = 0; c < period; c++) begin
                @(negedge clk);
                btn_in = (t < high_ticks);
                ena    = (c == period - 1);
                @(posedge clk);
                #1;
                if (c == period - 1) begin
                    got[0][t] = press_pulse;
                    got[1][t] = release_pulse;
                    got[2][t] = short_press;
                    got[3][t] = long_press;
                    got[4][t] = repeat_pulse;
                    got[5][t] = held;
                end else if (any_pulse()) begin
                    wide_err++;
                end
            end
        end
        @(negedge clk);
        ena    = 1'b0;
        btn_in = 1'b0;
        @(posedge clk);
        #1;
        if (any_pulse()) wide_err++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [5:0] exp_v;
        rst    = 1'b0;
        ena    = 1'b1;
        btn_in = 1'b1;
        #2;
        exp_v = 6'b0;
        checks++;
        if ({press_pulse, release_pulse, short_press, long_press, repeat_pulse, held} !== exp_v) begin
            failures++;
            $display("FAIL reset_async outputs got=%b want=%b",
                     {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held}, exp_v);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({press_pulse, release_pulse, short_press, long_press, repeat_pulse, held} !== exp_v) begin
            failures++;
            $display("FAIL reset_held outputs got=%b want=%b",
                     {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held}, exp_v);
        end
        @(negedge clk);
        btn_in = 1'b0;
        ena    = 1'b0;
        rst    = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_short_tap();
        logic [63:0] exp_v [6];
        exp_v = '{64'h1, 64'h8, 64'h8, 64'h0, 64'h0, 64'h7};
        run_seq(3, 1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp_v[i]) begin
                failures++;
                $display("FAIL short_tap_%s got=%h want=%h", names[i], got[i], exp_v[i]);
            end
        end
        checks++;
        if (wide_err !== 0) begin
            failures++;
            $display("FAIL short_tap_width stray=%0d want=0", wide_err);
        end
    endtask

    task automatic test_long_hold(input int period, input string tag);
        logic [63:0] exp_v [6];
`ifdef BTN_AUTOREPEAT_EN
        exp_v = '{64'h1, 64'h100000, 64'h0, 64'h100, 64'h24800, 64'hFFFFF};
`else
        exp_v = '{64'h1, 64'h100000, 64'h0, 64'h100, 64'h0, 64'hFFFFF};
`endif
        run_seq(20, period);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp_v[i]) begin
                failures++;
                $display("FAIL %s_%s got=%h want=%h", tag, names[i], got[i], exp_v[i]);
            end
        end
        checks++;
        if (wide_err !== 0) begin
            failures++;
            $display("FAIL %s_width stray=%0d want=0", tag, wide_err);
        end
    endtask

    task automatic test_threshold();
        logic [63:0] exp_a [6];
        logic [63:0] exp_b [6];
        exp_a = '{64'h1, 64'h100, 64'h100, 64'h0, 64'h0, 64'hFF};
        exp_b = '{64'h1, 64'h200, 64'h0, 64'h100, 64'h0, 64'h1FF};
        run_seq(8, 1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp_a[i]) begin
                failures++;
                $display("FAIL thresh_release_%s got=%h want=%h", names[i], got[i], exp_a[i]);
            end
        end
        run_seq(9, 1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL thresh_long_%s got=%h want=%h", names[i], got[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_long();
        logic [5:0] obs;
        for (int t = 0; t <= 10; t++) begin
            @(negedge clk);
            btn_in = 1'b1;
            ena    = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (held !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre_held got=%b want=1", held);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        obs = {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held};
        checks++;
        if (obs !== 6'b0) begin
            failures++;
            $display("FAIL midrst_async outputs got=%b want=000000", obs);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            obs = {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held};
            checks++;
            if (obs !== 6'b0) begin
                failures++;
                $display("FAIL midrst_hold%0d outputs got=%b want=000000", c, obs);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b0;
        @(posedge clk);
        #1;
        obs = {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held};
        checks++;
        if (obs !== 6'b0) begin
            failures++;
            $display("FAIL midrst_noena outputs got=%b want=000000", obs);
        end
        @(negedge clk);
        ena = 1'b1;
        @(posedge clk);
        #1;
        obs = {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held};
        checks++;
        if (obs !== 6'b100001) begin
            failures++;
            $display("FAIL midrst_repress outputs got=%b want=100001", obs);
        end
        @(negedge clk);
        btn_in = 1'b0;
        @(posedge clk);
        #1;
        obs = {press_pulse, release_pulse, short_press, long_press, repeat_pulse, held};
        checks++;
        if (obs !== 6'b011000) begin
            failures++;
            $display("FAIL midrst_release outputs got=%b want=011000", obs);
        end
        @(negedge clk);
        ena = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_short_tap();
        test_long_hold(1, "long_hold");
        test_threshold();
        test_long_hold(4, "gated");
        test_reset_mid_long();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the single-bit output of the debouncer and turns it into one-clock event pulses for the timer/stopwatch control logic: press, release, short press, long press and auto-repeat while held.
- Sits directly downstream of sig_debouncer, one instance per front-panel button.
- Runs on the same clock and the same `ena` tick as the debouncer, so all durations are counted in ena ticks.

Parameters:
- LONG_CYCLES, 1000, number of ena ticks the button must be held before a press counts as long. Legal range ≥ 2.
- REPEAT_CYCLES, 250, number of ena ticks between auto-repeat pulses once the press is long. Legal range ≥ 1.
- Counter width is derived internally as $clog2 of the larger of the two parameters, plus 1. It is not a parameter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  tick enable; state advances only on clk edges where ena=1.
- btn_in  in  1  debounced button level (1 = pressed).
- press_pulse  out  1  one-clk pulse when a press is accepted.
- release_pulse  out  1  one-clk pulse when the button is released.
- short_press  out  1  one-clk pulse on release before long threshold.
- long_press  out  1  one-clk pulse when the hold reaches LONG_CYCLES.
- repeat_pulse  out  1  one-clk pulse every REPEAT_CYCLES while in long hold.
- held  out  1  level; 1 while state is not IDLE.

Behaviour:
- Reset: rst=0 asynchronously forces state=IDLE and cnt=0, and drives every output to 0. Reset asserted mid-press discards that press; no release or short pulse is generated.
- Outputs are all registered. Each pulse output is high for exactly one clk, following the ena=1 edge that detected its event. Pulse registers clear on the next clk edge whether or not ena is high.
- With ena=0, state and cnt hold and no pulses are produced. btn_in changes between ena ticks are only seen at the next ena tick.
- FSM states: IDLE, PRESSED, LONG. All transitions below occur on ena=1 edges.
- IDLE
  - btn_in=1: go to PRESSED, cnt<=0, assert press_pulse.
  - btn_in=0: stay.
- PRESSED
  - btn_in=0: go to IDLE, assert short_press and release_pulse in the same clk.
  - btn_in=1 and cnt==LONG_CYCLES-1: go to LONG, cnt<=0, assert long_press.
  - btn_in=1 otherwise: cnt<=cnt+1.
- LONG
  - btn_in=0: go to IDLE, assert release_pulse only (no short_press).
  - btn_in=1 and cnt==REPEAT_CYCLES-1: cnt<=0, assert repeat_pulse.
  - btn_in=1 otherwise: cnt<=cnt+1.
- Latency, counted from the ena edge that asserts press_pulse:
  - long_press arrives exactly LONG_CYCLES ena ticks later.
  - The first repeat_pulse arrives REPEAT_CYCLES ticks after long_press, then one every REPEAT_CYCLES ticks.
- Release exactly at the threshold: if btn_in is sampled 0 on the tick where cnt==LONG_CYCLES-1, release wins and the press is short.
- If btn_in is already 1 when rst deasserts, the first ena tick registers a new press.
- cnt never wraps. It is reset at every state change and at every repeat.
- held = (state != IDLE). It is registered, so it rises with press_pulse and falls with release_pulse.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: repeat_pulse behaves as described above.
- Undefined:
  - repeat_pulse is tied to 0.
  - In LONG, cnt does not count.
  - LONG is left only by release.
  - All other behaviour is unchanged.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=3, ena=1 every clk, macro defined unless stated; E0 = first edge btn_in sampled 1):
- Short tap: btn_in high E0..E2, low at E3 → press_pulse after E0; short_press and release_pulse together after E3; long_press and repeat_pulse never assert; held high from E0 to E3.
- Long hold: btn_in high E0..E19, low at E20 → press after E0; long_press after E8; repeat_pulse after E11, E14 and E17; release_pulse after E20; short_press stays 0.
- Threshold boundary:
  - High E0..E7, low at E8 → short_press at E8, no long_press.
  - High E0..E8, low at E9 → long_press at E8, release at E9, no short_press.
- Enable gating: ena high every 4th clk, same 20-tick hold → identical event order, with long_press on the 8th ena tick after press; every pulse is exactly 1 clk wide.
- Reset mid-LONG: assert rst=0 after E10 with btn_in=1 → all outputs 0 immediately, no release_pulse; deassert with btn_in=1 → press_pulse on the first ena edge.
- Macro undefined, 20-tick hold → long_press after E8, repeat_pulse always 0, held stays 1 until release_pulse at E20.
